// File: rtl/check_pkg.sv
// rtl/check_pkg.sv - shared constants and types for the result checker
// Command codes must stay in step with the stimulus stage.
package check_pkg;

  localparam logic [4:0] SC_CMD_IDLE    = 5'b00000;
  localparam logic [4:0] SC_CMD_BITMASK = 5'b00001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_WRITE   = 2'd2
  } state_t;

  localparam int REC_WORDS = 4;

  // w0 carries pass in its MSB; tv_addr and actual are split at bit 16
  localparam int REC_PASS_BIT = 15;
  localparam int REC_HI_LSB   = 16;

endpackage

// File: rtl/check_wr.sv
// rtl/check_wr.sv - record serializer and write master for the result log
// Holds address/data steady under waitrequest; the log pointer advances per accepted word.
module check_wr
  import check_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 20,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RES_BASE   = 20'h80000
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  i_rewind,
  input  logic                                  i_load,
  input  logic [REC_WORDS-1:0][DATA_WIDTH-1:0]  i_words,
  input  logic                                  i_waitrequest,
  output logic                                  o_busy,
  output logic                                  o_last,
  output logic [ADDR_WIDTH-1:0]                 o_ptr,
  output logic [DATA_WIDTH-1:0]                 o_writedata
);

  localparam int                IDX_W    = $clog2(REC_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(REC_WORDS - 1);

  logic                                 r_busy;
  logic [IDX_W-1:0]                     r_idx;
  logic [ADDR_WIDTH-1:0]                r_ptr;
  logic [REC_WORDS-1:0][DATA_WIDTH-1:0] r_words;
  logic                                 w_accept;

  assign w_accept    = r_busy && !i_waitrequest;
  assign o_last      = w_accept && (r_idx == LAST_IDX);
  assign o_busy      = r_busy;
  assign o_ptr       = r_ptr;
  assign o_writedata = r_busy ? r_words[r_idx] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_idx   <= '0;
      r_ptr   <= RES_BASE;
      r_words <= '0;
    end else begin
      if (i_rewind) begin
        r_ptr <= RES_BASE;
      end
      if (i_load) begin
        r_busy  <= 1'b1;
        r_idx   <= '0;
        r_words <= i_words;
      end else if (w_accept) begin
        r_ptr <= r_ptr + 1'b1;
        r_idx <= r_idx + 1'b1;
        if (o_last) begin
          r_busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/check.sv
// rtl/check.sv - result checker: pops vector/result pairs, compares under mask, logs records
// One pop of both FIFOs per vector; records are dropped (overflow) rather than wrapping.
module check
  import check_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 20,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    BE_WIDTH   = DATA_WIDTH / 8,
  parameter int                    STF_WIDTH  = 24,
  parameter int                    CHF_WIDTH  = STF_WIDTH + ADDR_WIDTH,
  parameter int                    SCC_WIDTH  = 5,
  parameter int                    SCD_WIDTH  = 24,
  parameter logic [ADDR_WIDTH-1:0] RES_BASE   = 20'h80000,
  parameter logic [ADDR_WIDTH-1:0] RES_LIMIT  = 20'hFFFFF,
  parameter int                    FCNT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  done,
  input  logic [CHF_WIDTH-1:0]  cfifo_data,
  input  logic                  cfifo_rdempty,
  output logic                  cfifo_rdreq,
  input  logic [STF_WIDTH-1:0]  rfifo_data,
  input  logic                  rfifo_rdempty,
  output logic                  rfifo_rdreq,
  input  logic [SCC_WIDTH-1:0]  sc_cmd,
  input  logic [SCD_WIDTH-1:0]  sc_data,
  output logic                  sc_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BE_WIDTH-1:0]   mem_byteenable,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic                  mem_waitrequest,
  output logic [FCNT_WIDTH-1:0] fail_count,
  output logic                  overflow
);

  state_t                               r_state, w_next;
  logic [STF_WIDTH-1:0]                 r_expected, r_actual, r_bitmask, w_diff;
  logic [ADDR_WIDTH-1:0]                r_tv_addr, w_ptr;
  logic [FCNT_WIDTH-1:0]                r_fail_count;
  logic                                 r_overflow;
  logic                                 w_pop, w_pass, w_full, w_load, w_rewind;
  logic                                 w_last, w_busy, w_mask_we;
  logic [ADDR_WIDTH:0]                  w_ptr_end;
  logic [REC_WORDS-1:0][DATA_WIDTH-1:0] w_words;

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_pop) w_next = ST_COMPARE;
      ST_COMPARE: w_next = w_full ? ST_IDLE : ST_WRITE;
      ST_WRITE:   if (w_last) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop       = (r_state == ST_IDLE) && !cfifo_rdempty && !rfifo_rdempty;
    w_load      = (r_state == ST_COMPARE) && !w_full;
    w_rewind    = (r_state == ST_IDLE) && start;
    cfifo_rdreq = w_pop;
    rfifo_rdreq = w_pop;
    sc_ready    = (r_state == ST_IDLE);
    done        = (r_state == ST_IDLE) && cfifo_rdempty && rfifo_rdempty;
  end

  always_comb begin
    w_mask_we = 1'b0;
    if (r_state == ST_IDLE) begin
      case (sc_cmd)
        SC_CMD_BITMASK: w_mask_we = 1'b1;
        SC_CMD_IDLE:    w_mask_we = 1'b0;
        default:        w_mask_we = 1'b0;
      endcase
    end
  end

  // Full check is done at one extra bit so a pointer near the top of memory cannot wrap
  assign w_diff    = (r_expected ^ r_actual) & r_bitmask;
  assign w_pass    = (w_diff == '0);
  assign w_ptr_end = {1'b0, w_ptr} + (ADDR_WIDTH + 1)'(REC_WORDS - 1);
  assign w_full    = (w_ptr_end > {1'b0, RES_LIMIT});

  always_comb begin
    w_words = '0;
    w_words[0][REC_PASS_BIT] = w_pass;
    w_words[0][ADDR_WIDTH-REC_HI_LSB-1:0] = r_tv_addr[ADDR_WIDTH-1:REC_HI_LSB];
    w_words[1] = r_tv_addr[REC_HI_LSB-1:0];
    w_words[2][STF_WIDTH-REC_HI_LSB-1:0] = r_actual[STF_WIDTH-1:REC_HI_LSB];
    w_words[3] = r_actual[REC_HI_LSB-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_expected   <= '0;
      r_actual     <= '0;
      r_tv_addr    <= '0;
      r_bitmask    <= '1;
      r_fail_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_expected <= cfifo_data[CHF_WIDTH-1:ADDR_WIDTH];
        r_tv_addr  <= cfifo_data[ADDR_WIDTH-1:0];
        r_actual   <= rfifo_data;
      end
      if (w_mask_we) r_bitmask <= sc_data[STF_WIDTH-1:0];
      if (w_rewind) begin
        r_fail_count <= '0;
        r_overflow   <= 1'b0;
      end else if (r_state == ST_COMPARE) begin
        if (!w_pass && (r_fail_count != '1)) r_fail_count <= r_fail_count + 1'b1;
        if (w_full) r_overflow <= 1'b1;
      end
    end
  end

  check_wr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RES_BASE   (RES_BASE)
  ) u_wr (
    .clock         (clock),
    .reset         (reset),
    .i_rewind      (w_rewind),
    .i_load        (w_load),
    .i_words       (w_words),
    .i_waitrequest (mem_waitrequest),
    .o_busy        (w_busy),
    .o_last        (w_last),
    .o_ptr         (w_ptr),
    .o_writedata   (mem_writedata)
  );

  assign mem_write      = w_busy;
  assign mem_address    = w_ptr;
  assign mem_byteenable = '1;
  assign fail_count     = r_fail_count;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_check.sv
// tb/tb_check.sv - directed bench for check with a record-level scoreboard
// Instance a uses the full log; instance b has a tiny log to exercise overflow.
module tb_check;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, start, done, cfifo_rdempty, cfifo_rdreq, rfifo_rdempty, rfifo_rdreq;
  logic [43:0] cfifo_data;
  logic [23:0] rfifo_data, sc_data;
  logic [4:0]  sc_cmd;
  logic        sc_ready, mem_write, mem_waitrequest, overflow;
  logic [19:0] mem_address;
  logic [1:0]  mem_byteenable;
  logic [15:0] mem_writedata, fail_count;

  logic        b_start, b_done, b_cempty, b_crdreq, b_rempty, b_rrdreq, b_ready, b_write, b_overflow;
  logic [43:0] b_cdata;
  logic [23:0] b_rdata;
  logic [19:0] b_address;
  logic [1:0]  b_be;
  logic [15:0] b_wdata, b_fail;

  check u_a (
    .clock(clock), .reset(reset), .start(start), .done(done),
    .cfifo_data(cfifo_data), .cfifo_rdempty(cfifo_rdempty), .cfifo_rdreq(cfifo_rdreq),
    .rfifo_data(rfifo_data), .rfifo_rdempty(rfifo_rdempty), .rfifo_rdreq(rfifo_rdreq),
    .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_ready(sc_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
    .fail_count(fail_count), .overflow(overflow)
  );

  check #(.RES_LIMIT(20'h80005)) u_b (
    .clock(clock), .reset(reset), .start(b_start), .done(b_done),
    .cfifo_data(b_cdata), .cfifo_rdempty(b_cempty), .cfifo_rdreq(b_crdreq),
    .rfifo_data(b_rdata), .rfifo_rdempty(b_rempty), .rfifo_rdreq(b_rrdreq),
    .sc_cmd(5'd0), .sc_data(24'd0), .sc_ready(b_ready),
    .mem_address(b_address), .mem_byteenable(b_be), .mem_write(b_write),
    .mem_writedata(b_wdata), .mem_waitrequest(1'b0),
    .fail_count(b_fail), .overflow(b_overflow)
  );

  int n_pass = 0, n_tot = 0;
  int a_wr = 0, b_wr = 0;
  logic [19:0] b_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Bench-side FIFOs, expected write stream and the observed log memory
  logic [43:0] cq[$];
  logic [23:0] rq[$];
  logic [35:0] expq[$];
  logic [15:0] mlog [logic [19:0]];
  logic [19:0] m_ptr;
  logic [23:0] m_mask;
  logic [15:0] m_fc;

  function automatic void refresh();
    cfifo_rdempty = (cq.size() == 0);
    cfifo_data    = (cq.size() != 0) ? cq[0] : 44'd0;
    rfifo_rdempty = (rq.size() == 0);
    rfifo_data    = (rq.size() != 0) ? rq[0] : 24'd0;
  endfunction

  function automatic void model_push(input logic [23:0] e, input logic [19:0] ad,
                                     input logic [23:0] a, input bit with_r);
    logic        pass;
    logic [15:0] w[4];
    pass = (((e ^ a) & m_mask) == 24'd0);
    if (!pass && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    w[0] = {pass, 11'd0, ad[19:16]};
    w[1] = ad[15:0];
    w[2] = {8'd0, a[23:16]};
    w[3] = a[15:0];
    for (int i = 0; i < 4; i++) expq.push_back({m_ptr + 20'(i), w[i]});
    m_ptr = m_ptr + 20'd4;
    cq.push_back({e, ad});
    if (with_r) rq.push_back(a);
    refresh();
  endfunction

  logic pc, pr;
  always @(posedge clock) begin
    pc = cfifo_rdreq;
    pr = rfifo_rdreq;
    #1;
    if (pc && cq.size() != 0) void'(cq.pop_front());
    if (pr && rq.size() != 0) void'(rq.pop_front());
    refresh();
  end

  logic        held;
  logic [19:0] h_addr;
  logic [15:0] h_data;
  logic [35:0] e_item;
  always @(negedge clock) begin
    if (!reset && mem_write) begin
      if (mem_waitrequest) begin
        if (held) begin
          chk("hold_addr", mem_address, h_addr);
          chk("hold_data", mem_writedata, h_data);
        end
        held = 1'b1; h_addr = mem_address; h_data = mem_writedata;
      end else begin
        held = 1'b0;
        a_wr++;
        mlog[mem_address] = mem_writedata;
        if (expq.size() == 0) chk("unexpected_write", {mem_address, mem_writedata}, 36'd0);
        else begin
          e_item = expq.pop_front();
          chk("wr_addr", mem_address, e_item[35:16]);
          chk("wr_data", mem_writedata, e_item[15:0]);
        end
      end
    end else held = 1'b0;
    if (!reset && b_write) begin
      b_wr++;
      b_last = b_address;
    end
  end

  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic wait_a(input string nm);
    int n = 0;
    while (!(done && expq.size() == 0) && n < 300) begin tick(); n++; end
    chk({nm, "_timeout"}, (n < 300), 1'b1);
    chk({nm, "_fail_count"}, fail_count, m_fc);
    chk({nm, "_overflow"}, overflow, 1'b0);
  endtask

  task automatic b_vec(input logic [23:0] e, input logic [19:0] ad, input logic [23:0] a);
    int n = 0;
    b_cdata = {e, ad}; b_rdata = a; b_cempty = 1'b0; b_rempty = 1'b0;
    #1;
    while (!b_crdreq && n < 20) begin tick(); n++; end
    chk("b_pop_both", {b_crdreq, b_rrdreq}, 2'b11);
    tick();
    b_cempty = 1'b1; b_rempty = 1'b1;
    n = 0;
    while (!b_done && n < 50) begin tick(); n++; end
    chk("b_timeout", (n < 50), 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; sc_cmd = 5'd0; sc_data = 24'd0; mem_waitrequest = 1'b0;
    b_start = 1'b0; b_cempty = 1'b1; b_rempty = 1'b1; b_cdata = 44'd0; b_rdata = 24'd0;
    held = 1'b0; b_last = 20'd0;
    m_ptr = 20'h80000; m_mask = 24'hFFFFFF; m_fc = 16'd0;
    refresh();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_sc_ready", sc_ready, 1'b1);
    chk("rst_done", done, 1'b1);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_address", mem_address, 20'h80000);
    chk("rst_writedata", mem_writedata, 16'h0000);
    chk("rst_counters", {fail_count, overflow}, 17'd0);
    chk("rst_rdreq", {cfifo_rdreq, rfifo_rdreq}, 2'b00);
    chk("rst_byteenable", mem_byteenable, 2'b11);

    // matching vector under full mask; pop -> COMPARE -> first write
    model_push(24'hA5A5A5, 20'h00012, 24'hA5A5A5, 1'b1);
    #1;
    chk("t1_pop_both", {cfifo_rdreq, rfifo_rdreq}, 2'b11);
    tick();
    chk("t1_compare_no_write", mem_write, 1'b0);
    tick();
    chk("t1_first_write", {mem_write, mem_address}, {1'b1, 20'h80000});
    wait_a("t1");
    chk("t1_w0", mlog[20'h80000], 16'h8000);
    chk("t1_w1", mlog[20'h80001], 16'h0012);
    chk("t1_w2", mlog[20'h80002], 16'h00A5);
    chk("t1_w3", mlog[20'h80003], 16'hA5A5);
    chk("t1_fail_lit", fail_count, 16'd0);

    // narrow mask: upper-byte difference ignored, low-byte difference counted
    sc_cmd = 5'd1; sc_data = 24'h0000FF;
    tick();
    sc_cmd = 5'd0; sc_data = 24'd0;
    m_mask = 24'h0000FF;
    model_push(24'h123456, 20'h00034, 24'hFF3456, 1'b1);
    model_push(24'h123456, 20'h00035, 24'h123400, 1'b1);
    wait_a("t2");
    chk("t2_pass_w0", mlog[20'h80004], 16'h8000);
    chk("t2_fail_w0", mlog[20'h80008], 16'h0000);
    chk("t2_fail_w3", mlog[20'h8000B], 16'h3400);
    chk("t2_fail_lit", fail_count, 16'd1);

    // waitrequest held for 5 cycles on w1
    a_wr = 0;
    model_push(24'h0F0F0F, 20'hABCDE, 24'h0F0F0F, 1'b1);
    #1;
    tick(); tick(); tick();
    mem_waitrequest = 1'b1;
    repeat (5) tick();
    mem_waitrequest = 1'b0;
    wait_a("t3");
    chk("t3_write_count", a_wr, 4);
    chk("t3_w1", mlog[20'h8000D], 16'hBCDE);

    // CHECK_FIFO ready while result FIFO starves
    model_push(24'h000000, 20'h00777, 24'h00000F, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_no_pop", {cfifo_rdreq, rfifo_rdreq}, 2'b00);
      chk("t4_not_done", done, 1'b0);
    end
    rq.push_back(24'h00000F);
    refresh();
    #1;
    chk("t4_pop_both", {cfifo_rdreq, rfifo_rdreq}, 2'b11);
    wait_a("t4");
    chk("t4_fail_lit", fail_count, 16'd2);

    // start coincident with a pop rewinds the log for that very record
    start = 1'b1;
    m_ptr = 20'h80000; m_fc = 16'd0;
    model_push(24'hFFFFFF, 20'h50005, 24'hFFFFFF, 1'b1);
    #1;
    chk("t5_pop_with_start", {cfifo_rdreq, rfifo_rdreq}, 2'b11);
    tick();
    start = 1'b0;
    wait_a("t5");
    chk("t5_w0_at_base", mlog[20'h80000], 16'h8005);

    // reset in the middle of a record
    model_push(24'h000000, 20'h00009, 24'h000001, 1'b1);
    #1;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("t6_abort_write", mem_write, 1'b0);
    chk("t6_abort_addr", mem_address, 20'h80000);
    reset = 1'b0;
    expq.delete();
    m_ptr = 20'h80000; m_mask = 24'hFFFFFF; m_fc = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_fail_cleared", fail_count, 16'd0);
    model_push(24'h000001, 20'h00001, 24'h000000, 1'b1);
    wait_a("t6");
    chk("t6_w1", mlog[20'h80001], 16'h0001);
    chk("t6_w3", mlog[20'h80003], 16'h0000);
    chk("t6_fail_lit", fail_count, 16'd1);

    // tiny log: second record does not fit and is dropped
    b_vec(24'hAAAAAA, 20'h00100, 24'hAAAAAA);
    b_vec(24'h000000, 20'h00200, 24'h000001);
    chk("b_write_count", b_wr, 4);
    chk("b_last_addr", b_last, 20'h80003);
    chk("b_overflow", b_overflow, 1'b1);
    chk("b_fail_count", b_fail, 16'd1);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("b_start_clears", {b_overflow, b_fail}, 17'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/check.md
# check

Result checker that consumes the CHECK_FIFO written by the stimulus stage and a result FIFO filled by the DUT interface, one entry per applied test vector. It compares the captured DUT outputs against the expected vector under the current output bitmask, counts failures, and logs a 4-word result record per vector to external memory through an Avalon-MM write master. It also terminates the stimulus-to-check (sc_*) command channel, which updates the bitmask.

## Interface
- ADDR_WIDTH, 20, memory word address width
- DATA_WIDTH, 16, memory data width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- STF_WIDTH, 24, test vector width
- CHF_WIDTH, STF_WIDTH+ADDR_WIDTH, CHECK_FIFO entry: {expected[43:20], tv_addr[19:0]}
- SCC_WIDTH, 5 / SCD_WIDTH, 24, sc command / data widths
- RES_BASE, 20'h80000, first word address of the result log
- RES_LIMIT, 20'hFFFFF, last writable log word address
- FCNT_WIDTH, 16, fail counter width

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse: rewind log pointer, clear fail_count and overflow
- done  out  1  IDLE and both FIFOs empty
- cfifo_data  in  CHF_WIDTH  show-ahead head of CHECK_FIFO
- cfifo_rdempty  in  1 / cfifo_rdreq  out  1  pop CHECK_FIFO
- rfifo_data  in  STF_WIDTH  show-ahead head of result FIFO (actual DUT outputs)
- rfifo_rdempty  in  1 / rfifo_rdreq  out  1  pop result FIFO
- sc_cmd  in  SCC_WIDTH / sc_data  in  SCD_WIDTH  command from stimulus stage
- sc_ready  out  1  checker can accept an sc command
- mem_address  out  ADDR_WIDTH / mem_byteenable  out  BE_WIDTH (constant all-ones)
- mem_write  out  1 / mem_writedata  out  DATA_WIDTH / mem_waitrequest  in  1
- fail_count  out  FCNT_WIDTH  saturating failure count
- overflow  out  1  sticky: a record was dropped because the log was full

## Operation
- States: IDLE, COMPARE, WRITE.
- IDLE: when both FIFOs are non-empty, assert cfifo_rdreq and rfifo_rdreq together for exactly one cycle, latch expected, tv_addr, and actual, then go to COMPARE. Never pop only one FIFO.
- COMPARE, one cycle:
  - diff = (expected ^ actual) & bitmask; pass = (diff == 0).
  - On fail, fail_count increments, saturating at all-ones.
  - If ptr + 3 > RES_LIMIT (computed at ADDR_WIDTH+1 bits), set overflow and return to IDLE with no write.
  - Otherwise go to WRITE with word index 0.
- WRITE: hold mem_write with mem_address = ptr and mem_writedata = word[idx] until a cycle with mem_waitrequest low; on that cycle ptr and idx increment. After word 3 is accepted, return to IDLE.
- Record layout:
  - w0 = {pass, 11'b0, tv_addr[19:16]}
  - w1 = tv_addr[15:0]
  - w2 = {8'b0, actual[23:16]}
  - w3 = actual[15:0]
- sc_ready = (state == IDLE).
  - sc_cmd == 5'b00001 (BITMASK) in a cycle with sc_ready high: bitmask <= sc_data[STF_WIDTH-1:0].
  - Other codes are ignored, as is any command while sc_ready is low.
- start is honoured only in IDLE: ptr <= RES_BASE, fail_count <= 0, overflow <= 0; bitmask is unchanged. start outside IDLE is ignored.
- Reset values:
  - state IDLE, ptr RES_BASE, bitmask all-ones, fail_count 0, overflow 0.
  - mem_write 0, rdreqs 0, mem_writedata 0, mem_address RES_BASE.
  - sc_ready 1; done follows its definition.

## Timing
- Pop to first mem_write: 2 cycles (pop cycle, COMPARE cycle). With no waitrequest, a record takes 6 cycles and the next pop can occur in the cycle after w3 is accepted.
- The bitmask update and a pop in the same IDLE cycle are both performed. The new mask applies to that vector, because comparison uses the registered mask in COMPARE.
- start and a pop in the same cycle: both occur, and the record is written at RES_BASE.
- A start pulse on the same cycle as a fail increment in COMPARE is ignored (start is not honoured outside IDLE).
- Reset in WRITE aborts the record immediately. The partial record is not resumed, and both FIFO entries are lost.
- mem_address, mem_writedata, and mem_write stay stable while mem_waitrequest is high.
- fail_count updates at the end of COMPARE. overflow is set in the same cycle.

## Structure
- Package check_pkg holds:
  - SC_CMD_IDLE and SC_CMD_BITMASK, which must match the stimulus stage.
  - The state encoding.
  - REC_WORDS = 4.
  - The record field offsets.
- Sub-module check_wr: a 4-word record serializer and Avalon write master (ptr, idx, waitrequest hold). It takes a load strobe plus the four words and returns busy and the pointer. The top level keeps the FSM, compare logic, bitmask, and counters.

## Test plan
- Mask all-ones, expected 24'hA5A5A5, actual 24'hA5A5A5, tv_addr 20'h00012:
  - Words written at 80000..80003 = 8000, 0012, 00A5, A5A5.
  - fail_count stays 0.
- BITMASK command with sc_data 24'h0000FF, then expected 24'h123456, actual 24'hFF3456:
  - pass = 1.
  - Then actual 24'h123400 gives a fail, w0[15] = 0, and fail_count = 1.
- mem_waitrequest held high for 5 cycles on w1: address and data stay frozen, and the record completes with 4 writes only.
- RES_LIMIT = 20'h80005: the second vector is dropped, overflow = 1, only 4 writes occur, and fail_count still counts the second vector.
- cfifo non-empty while rfifo stays empty for 10 cycles: no pops and done = 0. When rfifo fills, both FIFOs are popped in the same cycle.
- Reset asserted mid-WRITE (after w1):
  - mem_write drops on the next edge and ptr returns to 80000.
  - start then fail_count returns to 0.
  - The next vector's record begins at 80000.
